// File: rtl/iurt_up_arbiter.sv
// Four-way round-robin arbiter that funnels requester bytes through a one-byte buffer to an upstream channel.
// Define IURT_ARB_HEADER_EN to prefix each new grant's byte run with a channel header byte {6'b101000, grant_id}.
module iurt_up_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  input  logic        data_up_ready,
  output logic        data_up_valid,
  output logic [7:0]  data_up,
  output logic [1:0]  grant_id,
  output logic        busy
);
  localparam int DATA_W = 8;
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

`ifdef IURT_ARB_HEADER_EN
  typedef enum logic [1:0] {ARB, HDR, SEND} state_t;
`else
  typedef enum logic [1:0] {ARB, SEND} state_t;
`endif

  state_t            state, state_nxt;
  logic [1:0]        grant_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [DATA_W-1:0] buf_data, buf_data_nxt, data_up_nxt;
  logic              buf_full, buf_full_nxt, dv_nxt;
  logic              at_limit, take;
`ifdef IURT_ARB_HEADER_EN
  logic [1:0]        last_hdr_id, last_hdr_nxt;
  logic              hdr_sent_valid, hdr_sent_nxt;
`endif

  // Search starts one past the previous grant and ends on the previous grant itself.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] vld);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (vld[idx]) rr_pick = idx;
    end
  endfunction

  assign at_limit = (cnt == HOLD_LIM);
  assign busy     = (state != ARB) || buf_full;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_id;
    cnt_nxt      = cnt;
    buf_data_nxt = buf_data;
    buf_full_nxt = buf_full;
    data_up_nxt  = data_up;
    dv_nxt       = 1'b0;
    req_ready    = 4'b0000;
`ifdef IURT_ARB_HEADER_EN
    last_hdr_nxt = last_hdr_id;
    hdr_sent_nxt = hdr_sent_valid;
`endif
    if (ce && (state == SEND) && !buf_full && !at_limit)
      req_ready = 4'b0001 << grant_id;
    take = |(req_valid & req_ready);

    // Drain only ever empties a full buffer; loads below only fill an empty one.
    if (buf_full && data_up_ready) begin
      data_up_nxt  = buf_data;
      dv_nxt       = 1'b1;
      buf_full_nxt = 1'b0;
    end

    case (state)
      ARB: begin
        if (|req_valid) begin
          grant_nxt = rr_pick(grant_id, req_valid);
          cnt_nxt   = '0;
`ifdef IURT_ARB_HEADER_EN
          if (!hdr_sent_valid || (grant_nxt != last_hdr_id)) state_nxt = HDR;
          else                                                state_nxt = SEND;
`else
          state_nxt = SEND;
`endif
        end
      end
`ifdef IURT_ARB_HEADER_EN
      HDR: begin
        if (!buf_full) begin
          buf_data_nxt = {6'b101000, grant_id};
          buf_full_nxt = 1'b1;
          last_hdr_nxt = grant_id;
          hdr_sent_nxt = 1'b1;
          state_nxt    = SEND;
        end
      end
`endif
      SEND: begin
        if (take) begin
          buf_data_nxt = req_data[{grant_id, 3'b000} +: DATA_W];
          buf_full_nxt = 1'b1;
          cnt_nxt      = cnt + 8'd1;
        end
        if (at_limit || (!buf_full && !req_valid[grant_id])) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ARB;
      grant_id       <= 2'd3;
      cnt            <= '0;
      buf_full       <= 1'b0;
      data_up_valid  <= 1'b0;
      data_up        <= '0;
`ifdef IURT_ARB_HEADER_EN
      last_hdr_id    <= 2'd0;
      hdr_sent_valid <= 1'b0;
`endif
    end else if (ce) begin
      state          <= state_nxt;
      grant_id       <= grant_nxt;
      cnt            <= cnt_nxt;
      buf_full       <= buf_full_nxt;
      data_up_valid  <= dv_nxt;
      data_up        <= data_up_nxt;
`ifdef IURT_ARB_HEADER_EN
      last_hdr_id    <= last_hdr_nxt;
      hdr_sent_valid <= hdr_sent_nxt;
`endif
    end
  end

  // Buffer contents are qualified by buf_full, so they need no reset.
  always_ff @(posedge clk) begin
    if (ce) buf_data <= buf_data_nxt;
  end
endmodule
